cnn_img_loader: RTL and testbench

//  Parametrised image loader between the UART receiver (rx_data/rx_rdy) and the CNN input RAM.

---
 rtl/cnn_img_loader.sv | 131 +++++++++++++
 tb/tb_cnn_img_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cnn_img_loader.sv
// cnn_img_loader: UART byte to PIX_W-bit pixel RAM loader with skid byte, overrun flag; CNN_LOADER_TIMEOUT_EN adds partial-frame timeout
module cnn_img_loader #(
    parameter int PIX_W       = 1,
    parameter int NUM_PIX     = 784,
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    input  logic              clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
    output logic              timeout
);
    localparam int PPB = 8 / PIX_W;
    typedef enum logic {IDLE, UNPACK} state_t;
    state_t            state_q, state_d;
    logic [7:0]        shift_q, shift_d, hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d, frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d, timeout_q, timeout_d;
    logic              last;
`ifdef CNN_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]   idle_q, idle_d;
`endif
    if (!(PIX_W == 1 || PIX_W == 2 || PIX_W == 4 || PIX_W == 8) || (NUM_PIX * PIX_W) % 8 != 0 ||
        (1 << ADDR_W) < NUM_PIX || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("cnn_img_loader: illegal parameter set");
    end
    always_comb begin
        last        = state_q == UNPACK && cnt_q == 3'(PPB - 1);
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        overrun_d   = overrun_q;
        ptr_d       = ptr_q;
        if (last && hold_full_q) begin
            shift_d     = hold_q;
            cnt_d       = '0;
            hold_full_d = rx_rdy;
            hold_d      = rx_rdy ? rx_data : hold_q;
        end else if (rx_rdy && (state_q == IDLE || last)) begin
            shift_d = rx_data;
            cnt_d   = '0;
            state_d = UNPACK;
        end else if (last) begin
            state_d = IDLE;
        end else if (state_q == UNPACK) begin
            cnt_d = cnt_q + 3'd1;
            if (rx_rdy && hold_full_q) begin
                overrun_d = 1'b1;
            end else if (rx_rdy) begin
                hold_d      = rx_data;
                hold_full_d = 1'b1;
            end
        end
        // outputs are registered, so the pixel for the next cycle is selected from the next shift state
        wr_en_d      = state_d == UNPACK;
        wr_addr_d    = wr_en_d ? ptr_q : wr_addr_q;
        wr_data_d    = wr_en_d ? PIX_W'(shift_d >> (cnt_d * PIX_W)) : wr_data_q;
        if (wr_en_d)
            ptr_d = ptr_q == ADDR_W'(NUM_PIX - 1) ? '0 : ptr_q + 1'b1;
        frame_done_d = wr_en_q && wr_addr_q == ADDR_W'(NUM_PIX - 1);
        timeout_d    = 1'b0;
`ifdef CNN_LOADER_TIMEOUT_EN
        idle_d = '0;
        if (state_q == IDLE && ptr_q != '0 && !rx_rdy) begin
            if (idle_q == TO_W'(TIMEOUT_CYC - 1)) begin
                timeout_d = 1'b1;
                ptr_d     = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
`endif
    end
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            cnt_q        <= '0;
            ptr_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef CNN_LOADER_TIMEOUT_EN
            idle_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
`ifdef CNN_LOADER_TIMEOUT_EN
            idle_q       <= idle_d;
`endif
        end
    end
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = state_q == UNPACK || hold_full_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;
endmodule

// File: tb/tb_cnn_img_loader.sv
// tb_cnn_img_loader: scoreboard bench for cnn_img_loader (PIX_W=1/784 and PIX_W=4/4 instances)
module tb_cnn_img_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       rst, clr1, clr4, rx_rdy1, rx_rdy4;
    logic [7:0] rx_data1, rx_data4;
    logic       wr_en1, busy1, fd1, ovr1, to1;
    logic [9:0] wr_addr1;
    logic [0:0] wr_data1;
    logic       wr_en4, busy4, fd4, ovr4, to4;
    logic [1:0] wr_addr4;
    logic [3:0] wr_data4;
    cnn_img_loader #(.PIX_W(1), .NUM_PIX(784), .ADDR_W(10), .TIMEOUT_CYC(100)) u1 (
        .clk(clk), .rst(rst), .rx_data(rx_data1), .rx_rdy(rx_rdy1), .clr(clr1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .busy(busy1),
        .frame_done(fd1), .overrun(ovr1), .timeout(to1));
    cnn_img_loader #(.PIX_W(4), .NUM_PIX(4), .ADDR_W(2), .TIMEOUT_CYC(100)) u4 (
        .clk(clk), .rst(rst), .rx_data(rx_data4), .rx_rdy(rx_rdy4), .clr(clr4),
        .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4), .busy(busy4),
        .frame_done(fd4), .overrun(ovr4), .timeout(to4));
    typedef struct {int addr; int data;} wr_t;
    wr_t q1[$], q4[$];
    wr_t e1, e4;
    int checks = 0, failures = 0, cyc = 0;
    int ptr1 = 0, ptr4 = 0, fd_cnt1 = 0, fd_cnt4 = 0, to_cnt1 = 0, to_cnt4 = 0;
    int last1 = -10, last4 = -10;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (wr_en1) begin
            if (q1.size() == 0) chk("u1_unexpected_write_addr", int'(wr_addr1), -1);
            else begin
                e1 = q1.pop_front();
                chk("u1_addr", int'(wr_addr1), e1.addr);
                chk("u1_data", int'(wr_data1), e1.data);
            end
            if (wr_addr1 == 10'd783) last1 = cyc;
        end
        if (fd1) begin
            fd_cnt1++;
            chk("u1_frame_done_latency", cyc, last1 + 1);
        end
        if (to1) to_cnt1++;
        if (wr_en4) begin
            if (q4.size() == 0) chk("u4_unexpected_write_addr", int'(wr_addr4), -1);
            else begin
                e4 = q4.pop_front();
                chk("u4_addr", int'(wr_addr4), e4.addr);
                chk("u4_data", int'(wr_data4), e4.data);
            end
            if (wr_addr4 == 2'd3) last4 = cyc;
        end
        if (fd4) begin
            fd_cnt4++;
            chk("u4_frame_done_latency", cyc, last4 + 1);
        end
        if (to4) to_cnt4++;
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic push1(input logic [7:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            q1.push_back('{ptr1, int'(b[k])});
            ptr1 = (ptr1 == 783) ? 0 : ptr1 + 1;
        end
    endtask
    task automatic send1(input logic [7:0] b);
        rx_data1 = b;
        rx_rdy1  = 1'b1;
        push1(b, 8);
        tick(1);
        rx_rdy1 = 1'b0;
    endtask
    task automatic send4(input logic [7:0] b);
        rx_data4 = b;
        rx_rdy4  = 1'b1;
        q4.push_back('{ptr4, int'(b[3:0])});
        ptr4 = (ptr4 + 1) % 4;
        q4.push_back('{ptr4, int'(b[7:4])});
        ptr4 = (ptr4 + 1) % 4;
        tick(1);
        rx_rdy4 = 1'b0;
    endtask
    task automatic chk_zero1(input string tag);
        chk({tag, "_wr_en"}, int'(wr_en1), 0);
        chk({tag, "_wr_addr"}, int'(wr_addr1), 0);
        chk({tag, "_wr_data"}, int'(wr_data1), 0);
        chk({tag, "_busy"}, int'(busy1), 0);
        chk({tag, "_frame_done"}, int'(fd1), 0);
        chk({tag, "_overrun"}, int'(ovr1), 0);
        chk({tag, "_timeout"}, int'(to1), 0);
    endtask
    initial begin
        rst = 1'b1; clr1 = 1'b0; clr4 = 1'b0;
        rx_rdy1 = 1'b0; rx_rdy4 = 1'b0; rx_data1 = '0; rx_data4 = '0;
        tick(3);
        chk_zero1("reset");
        chk("reset_u4_wr_en", int'(wr_en4), 0);
        chk("reset_u4_busy", int'(busy4), 0);
        rst = 1'b0;
        tick(1);
        // full 784-pixel frame, one byte every 11 cycles
        for (int i = 0; i < 98; i++) begin
            send1(8'(i * 29 + 7));
            tick(10);
        end
        tick(5);
        chk("frame_done_count", fd_cnt1, 1);
        chk("busy_after_frame", int'(busy1), 0);
        chk("queue_after_frame", q1.size(), 0);
        // 4-bit pixels, 4-pixel frame
        send4(8'h21);
        tick(3);
        send4(8'h43);
        tick(4);
        chk("u4_frame_done_count", fd_cnt4, 1);
        send4(8'h65);
        tick(4);
        chk("u4_frame_done_still_one", fd_cnt4, 1);
        chk("u4_queue_empty", q4.size(), 0);
        chk("u4_busy_idle", int'(busy4), 0);
        // back-to-back bytes: skid buffer then overrun drop
        chk("ptr_wrapped_model", ptr1, 0);
        send1(8'hA5);
        chk("latency_one_wr_en", int'(wr_en1), 1);
        chk("busy_unpack", int'(busy1), 1);
        send1(8'h3C);
        rx_data1 = 8'hFF;
        rx_rdy1  = 1'b1;
        tick(1);
        rx_rdy1 = 1'b0;
        tick(20);
        chk("overrun_set", int'(ovr1), 1);
        chk("busy_after_burst", int'(busy1), 0);
        chk("queue_after_burst", q1.size(), 0);
        // 10 bytes then clr together with a byte that must be dropped
        for (int i = 0; i < 10; i++) begin
            send1(8'(8'h11 * i));
            tick(10);
        end
        chk("overrun_sticky", int'(ovr1), 1);
        clr1 = 1'b1;
        rx_data1 = 8'hFF;
        rx_rdy1 = 1'b1;
        tick(1);
        clr1 = 1'b0;
        rx_rdy1 = 1'b0;
        chk("clr_wr_en", int'(wr_en1), 0);
        chk("clr_overrun", int'(ovr1), 0);
        chk("clr_busy", int'(busy1), 0);
        ptr1 = 0;
        tick(2);
        chk("clr_byte_no_overrun", int'(ovr1), 0);
        send1(8'h5A);
        tick(10);
        // partial frame left idle
        clr1 = 1'b1;
        tick(1);
        clr1 = 1'b0;
        ptr1 = 0;
        for (int i = 0; i < 5; i++) begin
            send1(8'(8'h3D + i));
            tick(10);
        end
        to_cnt1 = 0;
        tick(130);
`ifdef CNN_LOADER_TIMEOUT_EN
        chk("timeout_pulses", to_cnt1, 1);
        ptr1 = 0;
`else
        chk("timeout_pulses", to_cnt1, 0);
        chk("partial_ptr_model", ptr1, 40);
`endif
        send1(8'hC3);
        tick(10);
        chk("queue_after_timeout", q1.size(), 0);
        // rst on the 4th pixel with the hold buffer full
        rx_data1 = 8'h96;
        rx_rdy1 = 1'b1;
        push1(8'h96, 4);
        tick(1);
        rx_data1 = 8'h69;
        tick(1);
        rx_rdy1 = 1'b0;
        tick(1);
        chk("hold_full_busy", int'(busy1), 1);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_zero1("rst_mid");
        ptr1 = 0;
        ptr4 = 0;
        send1(8'h0F);
        tick(12);
        chk("queue_final_u1", q1.size(), 0);
        chk("queue_final_u4", q4.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
